// File: rtl/seq_shifter.sv
// Multi-cycle WIDTH-bit shifter (SLL/SRL/SRA/ROTR), at most STEP positions per clock.
// Valid/ready on both sides; one request in flight at a time.
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHAMT_W:0] StepC = (SHAMT_W + 1)'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q;
  logic [SHAMT_W:0] rem_q, rem_d, k;
  logic             in_ready_q, out_valid_q, busy_q;

  always_comb begin
    k      = (rem_q < StepC) ? rem_q : StepC;
    rem_d  = rem_q - k;
    work_d = work_q;
    case (op_q)
      2'b00:   work_d = work_q << k;
      2'b01:   work_d = work_q >> k;
      // The MSB never changes under an arithmetic shift, so it still holds the original sign.
      2'b10:   work_d = $signed(work_q) >>> k;
      2'b11:   work_d = (work_q >> k) | (work_q << (WIDTH - k));
      default: work_d = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      work_q      <= '0;
      op_q        <= 2'b00;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q     <= data_in;
            op_q       <= op;
            rem_q      <= {1'b0, shamt};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (shamt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) state_q <= StDone;
        end
        StDone: begin
          // out_valid registers one cycle after DONE is entered: latency is ceil(shamt/STEP)+1.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: three instances (32/4, 16/1, 32/32) share stimulus buses.
// Expected results come from a per-bit reference model; a negedge monitor pops and compares.
module tb_seq_shifter;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  iv;
  logic [1:0]  op;
  logic [31:0] din;
  logic [4:0]  sh;
  logic        ready_ctl, ready_rnd, rnd_bp;
  wire         out_ready = rnd_bp ? ready_rnd : ready_ctl;
  logic [2:0]  rdy, ov, bsy;
  logic [31:0] dout0, dout2;
  logic [15:0] dout1;

  exp_t sb[$];
  int   cyc = 0;
  int   vecs = 0;
  int   miscompares = 0;
  int   rise_cyc [3];
  logic [2:0] ov_prev;

  seq_shifter #(.WIDTH(32), .STEP(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .op(op), .data_in(din),
    .shamt(sh), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout0), .busy(bsy[0])
  );
  seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .op(op), .data_in(din[15:0]),
    .shamt(sh[3:0]), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout1), .busy(bsy[1])
  );
  seq_shifter #(.WIDTH(32), .STEP(32)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .op(op), .data_in(din),
    .shamt(sh), .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout2), .busy(bsy[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    ready_rnd = 1'($urandom_range(0, 1));
  end

  function automatic int wid(int g);
    return (g == 1) ? 16 : 32;
  endfunction

  function automatic int stp(int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 32;
  endfunction

  // Bit i of the result is taken from the source bit the shift rule names.
  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] d, int s, int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (o)
        2'd0:    r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'd1:    r[i] = (i + s < w) ? d[i+s] : 1'b0;
        2'd2:    r[i] = (i + s < w) ? d[i+s] : d[w-1];
        default: r[i] = d[(i+s)%w];
      endcase
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns just after a rising edge once nothing is outstanding.
  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      vecs++;
      miscompares++;
      $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic send(int g, logic [1:0] o, logic [31:0] d, int s, bit push);
    exp_t e;
    wait_done();
    #1;
    op    = o;
    din   = d;
    sh    = 5'(s);
    iv[g] = 1'b1;
    if (push) begin
      e.id  = g;
      e.exp = ref_shift(o, d, s, wid(g));
      e.acc = cyc + 1;
      e.lat = (s + stp(g) - 1) / stp(g) + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
    op    = 2'($urandom);
    din   = $urandom;
    sh    = 5'($urandom);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    if (reset) begin
      ov_prev = '0;
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (ov[g] && !ov_prev[g]) rise_cyc[g] = cyc;
        if (ov[g] && out_ready) begin
          act = (g == 0) ? dout0 : (g == 1) ? {16'h0, dout1} : dout2;
          vecs++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out dut%0d: got %h, want no result", g, act);
          end else begin
            e = sb.pop_front();
            if (e.id != g || act !== e.exp) begin
              miscompares++;
              $display("FAIL data dut%0d: got %h, want %h from dut%0d", g, act, e.exp, e.id);
            end
            vecs++;
            if (rise_cyc[g] - e.acc != e.lat) begin
              miscompares++;
              $display("FAIL latency dut%0d: got %0d, want %0d", g, rise_cyc[g] - e.acc, e.lat);
            end
          end
        end
      end
      ov_prev = ov;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s, w;
    reset = 1'b1; iv = '0; op = '0; din = '0; sh = '0;
    ready_ctl = 1'b1; rnd_bp = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(rdy[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_data_out", dout0, 32'h0);

    send(0, 2'd0, 32'hFFFF_FFFF, 2, 1);
    check("busy_after_accept", 32'(bsy[0]), 32'd1);
    wait_done();
    @(negedge clk);
    check("in_ready_after_release", 32'(rdy[0]), 32'd1);
    send(0, 2'd2, 32'h8000_0000, 31, 1);
    send(0, 2'd1, 32'h8000_0000, 31, 1);
    send(0, 2'd3, 32'h0000_0001, 1, 1);
    send(0, 2'd3, 32'h1234_5678, 16, 1);
    send(0, 2'd0, 32'hDEAD_BEEF, 0, 1);

    // Backpressure: result must hold and a stray request must be ignored.
    wait_done();
    #1 ready_ctl = 1'b0;
    send(0, 2'd1, 32'hF000_0000, 4, 1);
    for (int i = 0; i < 20 && !ov[0]; i++) @(negedge clk);
    check("bp_valid_seen", 32'(ov[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", dout0, 32'h0F00_0000);
      check("bp_hold_valid", 32'(ov[0]), 32'd1);
      check("bp_in_ready_low", 32'(rdy[0]), 32'd0);
      iv[0] = 1'b1;
      din   = 32'hA5A5_0001;
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    ready_ctl = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    check("bp_no_second_accept", 32'(bsy[0]), 32'd0);

    // Reset in the middle of a shift discards the request.
    send(0, 2'd0, 32'h0000_0001, 20, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    check("midrst_data_out", dout0, 32'h0);
    check("midrst_in_ready", 32'(rdy[0]), 32'd1);
    repeat (12) @(posedge clk);
    send(0, 2'd0, 32'h0000_0001, 3, 1);

    // Reset wins over a simultaneous request.
    wait_done();
    #1;
    reset = 1'b1; iv[0] = 1'b1; din = 32'h1; sh = 5'd1;
    @(posedge clk);
    #1;
    reset = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    check("rst_vs_valid_busy", 32'(bsy[0]), 32'd0);
    check("rst_vs_valid_ready", 32'(rdy[0]), 32'd1);

    send(1, 2'd2, 32'h0000_8001, 15, 1);
    send(2, 2'd3, 32'h1234_5678, 31, 1);

    rnd_bp = 1'b1;
    for (int n = 0; n < 90; n++) begin
      g = n % 3;
      w = wid(g);
      s = $urandom_range(0, w - 1);
      din = $urandom;
      if (w == 16) din[31:16] = '0;
      send(g, 2'($urandom), din, s, 1);
    end
    wait_done();
    rnd_bp = 1'b0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
